router_fifo: RTL
================

// Module: router_fifo
// PURPOSE
//   Per-destination packet FIFO downstream of router_reg: buffers bytes from router_reg dout,
//   tags each header byte and delivers bytes to the read side. Tracks packet boundaries:
//   loads a byte counter from each header's length field, flags last (parity) byte on read.
//   Three instances per router, one per destination port.
// PARAMETERS
//   WIDTH   8   data byte width; stored word is WIDTH+1 (bit WIDTH = header flag)
//   DEPTH   16  number of entries; power of two
//   AW      4   address width, log2(DEPTH); pointers are AW+1 bits (MSB = wrap bit)
// PORTS
//   clock       in   1      rising-edge clock
//   resetn      in   1      asynchronous active-low reset
//   soft_reset  in   1      synchronous flush (read-side timeout), active-high
//   write_enb   in   1      write request
//   read_enb    in   1      read request
//   lfd_state   in   1      FSM load-first-data state; marks header byte
//   data_in     in   WIDTH  byte from router_reg dout
//   data_out    out  WIDTH  registered read data
//   pkt_end     out  1      high while data_out holds the last byte (parity) of a packet
//   full        out  1      DEPTH entries stored
//   empty       out  1      no entries stored
// BEHAVIOUR
// - resetn low (async): wr_ptr=rd_ptr=0, count=0, lfd_d=0, data_out=0, pkt_end=0
//   -> empty=1, full=0. Memory contents not cleared.
// - soft_reset high at edge: same clear as resetn, synchronously; overrides read/write that cycle.
// - lfd_d <= lfd_state every cycle. Header flag stored with a write = lfd_d
//   (router_reg dout lags lfd_state by one cycle).
// - empty = (wr_ptr == rd_ptr); full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]).
//   Both combinational from pointers.
// - Write: write_enb && !full -> mem[wr_ptr[AW-1:0]] <= {lfd_d, data_in}; wr_ptr+1 (wraps mod 2*DEPTH).
//   Write when full is dropped silently, no state change.
// - Read: read_enb && !empty -> data_out <= mem[rd_ptr][WIDTH-1:0]; rd_ptr+1. 1-cycle latency.
//   Read when empty ignored; data_out, pkt_end hold.
// - Simultaneous read+write: both proceed if their own condition holds; full blocks write
//   using pre-read state (no write-through when full); empty blocks read (no bypass).
// - Packet counter count (7 bits), updated only on an accepted read of word w:
//     w header flag = 1 : count <= w[WIDTH-1:2] + 1 (payload + parity); pkt_end <= 0
//     else if count != 0: count <= count-1; pkt_end <= (count == 1)
//     else              : pkt_end <= 0 (orphan byte, no header seen)
//   No accepted read -> count, pkt_end hold.
//   Header with length 0 -> count=1; next read is parity, pkt_end=1.
// - pkt_end drops on next accepted read or soft_reset/resetn.
// - resetn/soft_reset mid-packet discard remaining bytes; counter restarts at next header.
// TESTING
// 1 resetn low 2 cycles -> empty=1, full=0, data_out=8'h00, pkt_end=0.
// 2 lfd_state=1 one cycle; then write header 8'h22 (len 8, addr 2), 8 payloads, parity;
//   then read 10 -> data_out sequence identical; pkt_end=1 only with parity byte; empty=1 after.
// 3 write 16 bytes 0x01..0x10 -> full=1 after 16th; 17th write 0xFF dropped;
//   read 16 -> 0x01..0x10, empty=1.
// 4 full FIFO, read_enb=write_enb=1 one cycle -> read of oldest occurs, write dropped,
//   full=0 after. Half-full, both=1 -> occupancy unchanged, data ordered.
// 5 write header 8'h22 + 3 bytes, read 2, soft_reset=1 -> empty=1, data_out=0, pkt_end=0;
//   new packet len 1 reads correctly with pkt_end on its parity.
// 6 interleave 40 writes/reads at occupancy 0..3 (pointer wrap twice) -> data order preserved;
//   read on empty leaves rd_ptr, data_out unchanged.

Source files
------------

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination packet FIFO with header tagging and packet-end tracking
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             pkt_end,
    output logic             full,
    output logic             empty
);

    localparam int CW = WIDTH - 1;
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [WIDTH:0]   mem [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             lfd_q, lfd_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pkt_end_q, pkt_end_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH:0]   rd_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        lfd_d      = lfd_state;
        data_out_d = data_out_q;
        pkt_end_d  = pkt_end_q;

        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            lfd_d      = 1'b0;
            data_out_d = '0;
            pkt_end_d  = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_word[WIDTH-1:0];
                // Header length field excludes the parity byte, hence the +1.
                if (rd_word[WIDTH]) begin
                    count_d   = {1'b0, rd_word[WIDTH-1:2]} + CNT_ONE;
                    pkt_end_d = 1'b0;
                end else if (count_q != '0) begin
                    count_d   = count_q - CNT_ONE;
                    pkt_end_d = (count_q == CNT_ONE);
                end else begin
                    pkt_end_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lfd_q      <= 1'b0;
            data_out_q <= '0;
            pkt_end_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lfd_q      <= lfd_d;
            data_out_q <= data_out_d;
            pkt_end_q  <= pkt_end_d;
        end
    end

    // Storage is not reset; the header flag is the delayed lfd since data lags the FSM by a cycle.
    always_ff @(posedge clock) begin
        if (wr_acc && !soft_reset) begin
            mem[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
        end
    end

    assign data_out = data_out_q;
    assign pkt_end  = pkt_end_q;

endmodule
